// File: rtl/alu_share_arbiter_if.sv
// Request, response and shared-ALU signal bundle for alu_share_arbiter.
// valid/ready: a transfer happens on a rising edge where valid and ready are both high; the source holds its payload stable while valid=1 and ready=0.
interface alu_share_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [2:0]       req0_op;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [2:0]       req1_op;

    logic             resp_valid;
    logic             resp_ready;
    logic             resp_id;
    logic [WIDTH-1:0] resp_result;
    logic             resp_zero;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_ctrl;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_op,
        output req1_ready,
        output resp_valid, resp_id, resp_result, resp_zero,
        input  resp_ready,
        output alu_a, alu_b, alu_ctrl,
        input  alu_result, alu_zero
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_op,
        input  req1_ready,
        input  resp_valid, resp_id, resp_result, resp_zero,
        output resp_ready,
        input  alu_a, alu_b, alu_ctrl,
        output alu_result, alu_zero
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one external combinational ALU between two requesters.
// One operation in flight at a time: IDLE (arbitrate) -> EXEC (capture ALU) -> RESP (hold until taken).
module alu_share_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    alu_share_arbiter_if.slave  bus,
    output logic                busy,
    output logic [1:0]          dbg_state
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             last_grant_q;
    logic             id_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [2:0]       op_q;
    logic             resp_valid_q;
    logic             resp_id_q;
    logic             resp_zero_q;
    logic [WIDTH-1:0] resp_result_q;
    logic             pick0;
    logic             pick1;

    // A tie goes to whoever was not granted last; reset leaves last_grant=1 so req0 wins first.
    always_comb begin
        state_d = state_q;
        pick0   = 1'b0;
        pick1   = 1'b0;
        case (state_q)
            IDLE: begin
                pick0 = bus.req0_valid && (!bus.req1_valid || last_grant_q);
                pick1 = bus.req1_valid && (!bus.req0_valid || !last_grant_q);
                if (pick0 || pick1) state_d = EXEC;
            end
            EXEC:    state_d = RESP;
            RESP:    if (bus.resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q  <= 1'b1;
            id_q          <= 1'b0;
            a_q           <= '0;
            b_q           <= '0;
            op_q          <= 3'b000;
            resp_valid_q  <= 1'b0;
            resp_id_q     <= 1'b0;
            resp_zero_q   <= 1'b0;
            resp_result_q <= '0;
        end else begin
            if (pick0 || pick1) begin
                a_q          <= pick1 ? bus.req1_a  : bus.req0_a;
                b_q          <= pick1 ? bus.req1_b  : bus.req0_b;
                op_q         <= pick1 ? bus.req1_op : bus.req0_op;
                id_q         <= pick1;
                last_grant_q <= pick1;
            end
            if (state_q == EXEC) begin
                resp_result_q <= bus.alu_result;
                resp_zero_q   <= bus.alu_zero;
                resp_id_q     <= id_q;
                resp_valid_q  <= 1'b1;
            end else if (state_q == RESP && bus.resp_ready) begin
                resp_valid_q  <= 1'b0;
            end
        end
    end

    assign bus.req0_ready  = pick0;
    assign bus.req1_ready  = pick1;
    assign bus.alu_a       = a_q;
    assign bus.alu_b       = b_q;
    assign bus.alu_ctrl    = op_q;
    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_id     = resp_id_q;
    assign bus.resp_result = resp_result_q;
    assign bus.resp_zero   = resp_zero_q;
    assign busy            = (state_q != IDLE);
    assign dbg_state       = state_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU and a response scoreboard.
module tb_alu_share_arbiter;
  localparam int WIDTH = 32;
  localparam int EW    = WIDTH + 2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       busy;
  logic [1:0] dbg_state;

  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_share_arbiter_if #(.WIDTH(WIDTH)) bus ();

  alu_share_arbiter #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // external ALU: 000 AND, 001 OR, 010 ADD, 011 SUB, else 0; zero means A==B
  always_comb begin
    case (bus.alu_ctrl)
      3'b000:  bus.alu_result = bus.alu_a & bus.alu_b;
      3'b001:  bus.alu_result = bus.alu_a | bus.alu_b;
      3'b010:  bus.alu_result = bus.alu_a + bus.alu_b;
      3'b011:  bus.alu_result = bus.alu_a - bus.alu_b;
      default: bus.alu_result = '0;
    endcase
    bus.alu_zero = (bus.alu_a == bus.alu_b);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic id, input logic zero, input logic [WIDTH-1:0] res);
    exp_q.push_back({id, zero, res});
  endtask

  task automatic monitor();
    logic [EW-1:0] e;
    if (bus.resp_valid === 1'b1 && bus.resp_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("resp_unexpected", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("resp_id", 64'(bus.resp_id), 64'(e[EW-1]));
        check("resp_zero", 64'(bus.resp_zero), 64'(e[EW-2]));
        check("resp_result", 64'(bus.resp_result), 64'(e[WIDTH-1:0]));
      end
    end
  endtask

  // inputs are set just after a falling edge; the monitor sees them before the next rising edge
  task automatic cycle();
    #1;
    monitor();
    @(negedge clk);
  endtask

  task automatic drive0(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [2:0] op);
    bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
  endtask

  task automatic drive1(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [2:0] op);
    bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic do_op(input string tag, input logic id, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic [2:0] op,
                       input logic zero, input logic [WIDTH-1:0] res);
    if (id) drive1(1'b1, a, b, op);
    else    drive0(1'b1, a, b, op);
    push_exp(id, zero, res);
    #1;
    check({tag, "_ready0"}, 64'(bus.req0_ready), 64'(!id));
    check({tag, "_ready1"}, 64'(bus.req1_ready), 64'(id));
    cycle();
    drive0(1'b0, '0, '0, 3'b000);
    drive1(1'b0, '0, '0, 3'b000);
    check({tag, "_exec_busy"}, 64'(busy), 64'd1);
    check({tag, "_exec_rv"}, 64'(bus.resp_valid), 64'd0);
    check({tag, "_alu_a"}, 64'(bus.alu_a), 64'(a));
    check({tag, "_alu_b"}, 64'(bus.alu_b), 64'(b));
    check({tag, "_alu_ctrl"}, 64'(bus.alu_ctrl), 64'(op));
    cycle();
    check({tag, "_latency_rv"}, 64'(bus.resp_valid), 64'd1);
    cycle();
    check({tag, "_back_idle"}, 64'(busy), 64'd0);
  endtask

  task automatic wait_grant(input string tag, input logic exp_id);
    int n = 0;
    while (!(bus.req0_ready || bus.req1_ready) && n < 8) begin
      cycle();
      n++;
    end
    check({tag, "_ready0"}, 64'(bus.req0_ready), 64'(!exp_id));
    check({tag, "_ready1"}, 64'(bus.req1_ready), 64'(exp_id));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n        = 1'b1;
    bus.resp_ready = 1'b1;
    drive0(1'b0, '0, '0, 3'b000);
    drive1(1'b0, '0, '0, 3'b000);
    #1 reset_n = 1'b0;
    #1;
    check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("rst_resp_result", 64'(bus.resp_result), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_alu_a", 64'(bus.alu_a), 64'd0);
    check("rst_alu_ctrl", 64'(bus.alu_ctrl), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    do_op("add0", 1'b0, 32'd5, 32'd7, 3'b010, 1'b0, 32'd12);
    do_op("sub1", 1'b1, 32'd3, 32'd5, 3'b011, 1'b0, 32'hFFFF_FFFE);
    do_op("sub1_eq", 1'b1, 32'h1234, 32'h1234, 3'b011, 1'b1, 32'd0);
    do_op("op111", 1'b0, 32'd9, 32'd9, 3'b111, 1'b1, 32'd0);

    // fairness under continuous contention, starting from reset
    do_reset();
    drive0(1'b1, 32'hF0, 32'h0F, 3'b001);
    drive1(1'b1, 32'hFF, 32'h3C, 3'b000);
    for (int i = 0; i < 4; i++) begin
      if (i[0]) push_exp(1'b1, 1'b0, 32'h3C);
      else      push_exp(1'b0, 1'b0, 32'hFF);
    end
    #1;
    for (int i = 0; i < 4; i++) begin
      wait_grant("fair", i[0]);
      cycle();
    end
    drive0(1'b0, '0, '0, 3'b000);
    drive1(1'b0, '0, '0, 3'b000);
    cycle();
    cycle();
    cycle();
    check("fair_drained", 64'(exp_q.size()), 64'd0);

    // backpressure on the response
    bus.resp_ready = 1'b0;
    drive0(1'b1, 32'hA, 32'h3, 3'b011);
    push_exp(1'b0, 1'b0, 32'd7);
    #1;
    check("bp_accept", 64'(bus.req0_ready), 64'd1);
    cycle();
    drive1(1'b1, 32'd1, 32'd1, 3'b000);
    cycle();
    for (int i = 0; i < 5; i++) begin
      check("bp_rv", 64'(bus.resp_valid), 64'd1);
      check("bp_result", 64'(bus.resp_result), 64'd7);
      check("bp_id", 64'(bus.resp_id), 64'd0);
      check("bp_busy", 64'(busy), 64'd1);
      check("bp_ready0", 64'(bus.req0_ready), 64'd0);
      check("bp_ready1", 64'(bus.req1_ready), 64'd0);
      cycle();
    end
    bus.resp_ready = 1'b1;
    drive0(1'b0, '0, '0, 3'b000);
    drive1(1'b0, '0, '0, 3'b000);
    cycle();
    check("bp_release_idle", 64'(busy), 64'd0);
    check("bp_release_rv", 64'(bus.resp_valid), 64'd0);

    // reset during EXEC discards the operation
    drive0(1'b1, 32'd2, 32'd2, 3'b010);
    #1;
    check("rx_accept", 64'(bus.req0_ready), 64'd1);
    cycle();
    drive0(1'b0, '0, '0, 3'b000);
    check("rx_in_exec", 64'(dbg_state), 64'd1);
    reset_n = 1'b0;
    #1;
    check("rx_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("rx_resp_id", 64'(bus.resp_id), 64'd0);
    check("rx_resp_result", 64'(bus.resp_result), 64'd0);
    check("rx_resp_zero", 64'(bus.resp_zero), 64'd0);
    check("rx_busy", 64'(busy), 64'd0);
    check("rx_alu_a", 64'(bus.alu_a), 64'd0);
    check("rx_alu_b", 64'(bus.alu_b), 64'd0);
    check("rx_alu_ctrl", 64'(bus.alu_ctrl), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    check("rx_no_resp_pending", 64'(exp_q.size()), 64'd0);
    drive0(1'b1, 32'd4, 32'd4, 3'b010);
    drive1(1'b1, 32'd6, 32'd1, 3'b011);
    push_exp(1'b0, 1'b1, 32'd8);
    #1;
    check("rx_tie_ready0", 64'(bus.req0_ready), 64'd1);
    check("rx_tie_ready1", 64'(bus.req1_ready), 64'd0);
    cycle();
    drive0(1'b0, '0, '0, 3'b000);
    drive1(1'b0, '0, '0, 3'b000);
    cycle();
    cycle();
    cycle();
    check("final_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
